// File: rtl/seq_divider_if.sv
// rtl/seq_divider_if.sv - start/busy/done divider port bundle; signed_op exists only with SEQ_DIV_SIGNED_EN
interface seq_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SEQ_DIV_SIGNED_EN
  logic             signed_op;
`endif
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;

  modport master (
    input  busy, done, div_by_zero, q, r,
    output start, a, b
`ifdef SEQ_DIV_SIGNED_EN
    , signed_op
`endif
  );

  modport slave (
    output busy, done, div_by_zero, q, r,
    input  start, a, b
`ifdef SEQ_DIV_SIGNED_EN
    , signed_op
`endif
  );
endinterface

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - restoring divider, one quotient bit per clock; SEQ_DIV_SIGNED_EN adds signed operation
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic          clock,
  input  logic          reset,
  seq_divider_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] quo_q, quo_d;     // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] rem_q, rem_d;     // partial remainder, always < divisor
  logic [WIDTH-1:0] div_q, div_d;     // divisor magnitude
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic             neg_q_q, neg_q_d; // negate quotient at the end
  logic             neg_r_q, neg_r_d; // negate remainder at the end

  logic             op_signed;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   rem_sh;
  logic             sub_ok;
  logic [WIDTH-1:0] rem_new, quo_new;

`ifdef SEQ_DIV_SIGNED_EN
  assign op_signed = bus.signed_op;
`else
  assign op_signed = 1'b0;
`endif

  // Operand magnitudes; the most negative value maps onto itself, which is its correct unsigned magnitude
  always_comb begin
    a_mag = (op_signed && bus.a[WIDTH-1]) ? (~bus.a + 1'b1) : bus.a;
    b_mag = (op_signed && bus.b[WIDTH-1]) ? (~bus.b + 1'b1) : bus.b;
  end

  // One restoring step: shift the next dividend bit into the remainder and trial-subtract
  always_comb begin
    rem_sh  = {rem_q, quo_q[WIDTH-1]};
    sub_ok  = (rem_sh >= {1'b0, div_q});
    rem_new = sub_ok ? WIDTH'(rem_sh - {1'b0, div_q}) : rem_sh[WIDTH-1:0];
    quo_new = {quo_q[WIDTH-2:0], sub_ok};
  end

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    done_d  = done_q;
    dbz_d   = dbz_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          if (bus.b == '0) begin
            // Divide by zero bypasses CALC and reports on the accept edge itself
            q_d     = '1;
            r_d     = bus.a;
            done_d  = 1'b1;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            quo_d   = a_mag;
            div_d   = b_mag;
            rem_d   = '0;
            cnt_d   = CNT_W'(WIDTH);
            neg_q_d = op_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_r_d = op_signed && bus.a[WIDTH-1];
            done_d  = 1'b0;
            dbz_d   = 1'b0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        quo_d = quo_new;
        rem_d = rem_new;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          // Last quotient bit: publish the result, applying signs for the signed case
          q_d     = neg_q_q ? (~quo_new + 1'b1) : quo_new;
          r_d     = neg_r_q ? (~rem_new + 1'b1) : rem_new;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      quo_q   <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else begin
      state_q <= state_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
    end
  end

  assign bus.busy        = (state_q == CALC);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.q           = q_q;
  assign bus.r           = r_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed bench for seq_divider at WIDTH 32 and 8
module tb_seq_divider;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc, bcnt;

  always #5 clock = ~clock;

  seq_divider_if #(.WIDTH(32)) i32 ();
  seq_divider_if #(.WIDTH(8))  i8 ();

  seq_divider #(.WIDTH(32)) u32 (.clock(clock), .reset(reset), .bus(i32));
  seq_divider #(.WIDTH(8))  u8  (.clock(clock), .reset(reset), .bus(i8));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one accept edge; returns at the negedge after that edge
  task automatic go32(input logic [31:0] a, input logic [31:0] b, input logic sop);
    @(negedge clock);
    i32.start = 1'b1;
    i32.a     = a;
    i32.b     = b;
`ifdef SEQ_DIV_SIGNED_EN
    i32.signed_op = sop;
`endif
    @(negedge clock);
    i32.start = 1'b0;
    if (sop) begin end
  endtask

  task automatic go8(input logic [7:0] a, input logic [7:0] b);
    @(negedge clock);
    i8.start = 1'b1;
    i8.a     = a;
    i8.b     = b;
    @(negedge clock);
    i8.start = 1'b0;
  endtask

  // Bounded wait for done; counts samples and how many of them saw busy
  task automatic wait32(output int c, output int bc);
    c = 0; bc = 0;
    while (!i32.done && c < 200) begin
      if (i32.busy) bc++;
      @(negedge clock);
      c++;
    end
  endtask

  task automatic wait8(output int c, output int bc);
    c = 0; bc = 0;
    while (!i8.done && c < 200) begin
      if (i8.busy) bc++;
      @(negedge clock);
      c++;
    end
  endtask

  initial begin
    i32.start = 1'b0; i32.a = '0; i32.b = '0;
    i8.start  = 1'b0; i8.a  = '0; i8.b  = '0;
`ifdef SEQ_DIV_SIGNED_EN
    i32.signed_op = 1'b0;
    i8.signed_op  = 1'b0;
`endif
    repeat (2) @(negedge clock);
    reset = 1'b0;

    chk("rst_busy", 64'(i32.busy), 64'd0);
    chk("rst_done", 64'(i32.done), 64'd0);
    chk("rst_dbz",  64'(i32.div_by_zero), 64'd0);
    chk("rst_q",    64'(i32.q), 64'd0);
    chk("rst_r",    64'(i32.r), 64'd0);

    // 100 / 7
    go32(32'd100, 32'd7, 1'b0);
    chk("b1_busy_start", 64'(i32.busy), 64'd1);
    chk("b1_q_held",     64'(i32.q), 64'd0);
    wait32(cyc, bcnt);
    chk("b1_latency", 64'(cyc), 64'd32);
    chk("b1_busycnt", 64'(bcnt), 64'd32);
    chk("b1_busy_end", 64'(i32.busy), 64'd0);
    chk("b1_q",   64'(i32.q), 64'd14);
    chk("b1_r",   64'(i32.r), 64'd2);
    chk("b1_dbz", 64'(i32.div_by_zero), 64'd0);

    // 5 / 0
    go32(32'd5, 32'd0, 1'b0);
    chk("dz_done", 64'(i32.done), 64'd1);
    chk("dz_dbz",  64'(i32.div_by_zero), 64'd1);
    chk("dz_busy", 64'(i32.busy), 64'd0);
    chk("dz_q",    64'(i32.q), 64'hFFFF_FFFF);
    chk("dz_r",    64'(i32.r), 64'd5);

    // start during CALC is ignored; q/r hold the previous result meanwhile
    go32(32'd100, 32'd7, 1'b0);
    chk("ig_done0", 64'(i32.done), 64'd0);
    chk("ig_dbz0",  64'(i32.div_by_zero), 64'd0);
    chk("ig_q_held", 64'(i32.q), 64'hFFFF_FFFF);
    chk("ig_r_held", 64'(i32.r), 64'd5);
    repeat (9) @(negedge clock);
    i32.start = 1'b1; i32.a = 32'd9; i32.b = 32'd3;
    @(negedge clock);
    i32.start = 1'b0;
    wait32(cyc, bcnt);
    chk("ig_latency", 64'(cyc), 64'd22);
    chk("ig_q", 64'(i32.q), 64'd14);
    chk("ig_r", 64'(i32.r), 64'd2);

    // reset mid-division
    go32(32'd1000, 32'd3, 1'b0);
    repeat (4) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("ab_busy", 64'(i32.busy), 64'd0);
    chk("ab_done", 64'(i32.done), 64'd0);
    chk("ab_q",    64'(i32.q), 64'd0);
    chk("ab_r",    64'(i32.r), 64'd0);
    go32(32'd9, 32'd3, 1'b0);
    wait32(cyc, bcnt);
    chk("ab_q2", 64'(i32.q), 64'd3);
    chk("ab_r2", 64'(i32.r), 64'd0);

    // back-to-back accept from DONE
    go32(32'd20, 32'd6, 1'b0);
    chk("bb_done0", 64'(i32.done), 64'd0);
    chk("bb_busy",  64'(i32.busy), 64'd1);
    wait32(cyc, bcnt);
    chk("bb_q", 64'(i32.q), 64'd3);
    chk("bb_r", 64'(i32.r), 64'd2);

    // WIDTH = 8 boundaries
    go8(8'd255, 8'd1);
    wait8(cyc, bcnt);
    chk("w8_latency", 64'(cyc), 64'd8);
    chk("w8_q1", 64'(i8.q), 64'd255);
    chk("w8_r1", 64'(i8.r), 64'd0);
    go8(8'd7, 8'd200);
    wait8(cyc, bcnt);
    chk("w8_q2", 64'(i8.q), 64'd0);
    chk("w8_r2", 64'(i8.r), 64'd7);

    // start held high: a new division begins on every non-busy edge
    @(negedge clock);
    i8.start = 1'b1; i8.a = 8'd50; i8.b = 8'd7;
    @(negedge clock);
    chk("hh_busy1", 64'(i8.busy), 64'd1);
    wait8(cyc, bcnt);
    chk("hh_lat1", 64'(cyc), 64'd8);
    chk("hh_q1", 64'(i8.q), 64'd7);
    chk("hh_r1", 64'(i8.r), 64'd1);
    i8.a = 8'd60;
    @(negedge clock);
    chk("hh_done2", 64'(i8.done), 64'd0);
    chk("hh_busy2", 64'(i8.busy), 64'd1);
    i8.start = 1'b0;
    wait8(cyc, bcnt);
    chk("hh_q2", 64'(i8.q), 64'd8);
    chk("hh_r2", 64'(i8.r), 64'd4);

`ifdef SEQ_DIV_SIGNED_EN
    go32(32'hFFFF_FFF9, 32'd2, 1'b1);
    wait32(cyc, bcnt);
    chk("s1_lat", 64'(cyc), 64'd32);
    chk("s1_q", 64'(i32.q), 64'hFFFF_FFFD);
    chk("s1_r", 64'(i32.r), 64'hFFFF_FFFF);
    go32(32'd7, 32'hFFFF_FFFE, 1'b1);
    wait32(cyc, bcnt);
    chk("s2_q", 64'(i32.q), 64'hFFFF_FFFD);
    chk("s2_r", 64'(i32.r), 64'd1);
    go32(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait32(cyc, bcnt);
    chk("s3_q", 64'(i32.q), 64'h8000_0000);
    chk("s3_r", 64'(i32.r), 64'd0);
    go32(32'hFFFF_FFF9, 32'd2, 1'b0);
    wait32(cyc, bcnt);
    chk("s4_q", 64'(i32.q), 64'h7FFF_FFFC);
    chk("s4_r", 64'(i32.r), 64'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
